mmio_responder: RTL and testbench

Memory-mapped I/O target for the 19-bit CPU's load/store path: the responder end of the CPU's address/data/control bus for the I/O address window. It accepts one read or write request at a time through a valid/ready handshake and inserts a fixed number of wait states. It returns read data or an error with a single-cycle response strobe. Behind the bus it holds two scratch registers, a free-running timer with compare interrupt, and a transmit FIFO drained by a downstream peripheral.

---
 rtl/mmio_responder_if.sv | 24 ++
 rtl/mmio_responder.sv | 162 ++++++++++++++++
 tb/tb_mmio_responder.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/mmio_responder_if.sv
// CPU <-> I/O window request/response bus: valid/ready request, single-cycle response strobe.
interface mmio_responder_if #(
  parameter int ADDR_SIZE = 19,
  parameter int WORD_SIZE = 19
);
  logic                 req_valid;
  logic                 req_write;
  logic [ADDR_SIZE-1:0] req_addr;
  logic [WORD_SIZE-1:0] req_wdata;
  logic                 req_ready;
  logic                 rsp_valid;
  logic [WORD_SIZE-1:0] rsp_rdata;
  logic                 rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mmio_responder.sv
// I/O window responder: scratch regs, free-running timer with compare irq, TX FIFO.
module mmio_responder #(
  parameter int                   WORD_SIZE   = 19,
  parameter int                   ADDR_SIZE   = 19,
  parameter logic [ADDR_SIZE-1:0] BASE_ADDR   = 19'h7FF00,
  parameter int                   WAIT_STATES = 1,
  parameter int                   FIFO_DEPTH  = 4
) (
  input  logic                 CLK,
  input  logic                 RESET,
  mmio_responder_if.slave      bus,
  output logic [WORD_SIZE-1:0] tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic                 irq
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [WORD_SIZE-1:0] ID_VAL = WORD_SIZE'(19'h1C0DE);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  typedef struct packed {
    logic                 write;
    logic [ADDR_SIZE-1:0] addr;
    logic [WORD_SIZE-1:0] wdata;
  } req_t;

  state_t               state;
  req_t                 req_q, req_c;
  logic [3:0]           cnt;
  logic                 rdy_q, rsp_valid_q, rsp_err_q;
  logic [WORD_SIZE-1:0] rsp_rdata_q;

  logic [WORD_SIZE-1:0] scratch0, scratch1, timer, timer_cmp;
  logic                 st_match, st_err, irq_en;

  logic [WORD_SIZE-1:0] mem [FIFO_DEPTH];
  logic [PW:0]          wptr, rptr, count;
  logic                 full, empty, pop, push;

  logic                 commit, in_range, wr, err_acc;
  logic [ADDR_SIZE-1:0] diff;
  logic [2:0]           off;
  logic [WORD_SIZE-1:0] rd_val, status_word;

  assign bus.req_ready = rdy_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

  // FIFO occupancy uses an extra pointer bit so full and empty are distinct.
  assign count    = wptr - rptr;
  assign empty    = (wptr == rptr);
  assign full     = (count == (PW+1)'(FIFO_DEPTH));
  assign tx_valid = !empty;
  assign tx_data  = tx_valid ? mem[rptr[PW-1:0]] : '0;
  assign pop      = tx_valid & tx_ready;
  assign irq      = st_match & irq_en;

  assign status_word = WORD_SIZE'({st_err, empty, full, st_match});

  // Decode the request that commits this edge: live inputs when entering RESP straight from IDLE.
  always_comb begin
    req_c = (state == IDLE) ? '{write: bus.req_write, addr: bus.req_addr, wdata: bus.req_wdata}
                            : req_q;
    commit   = ((state == IDLE) && bus.req_valid && rdy_q && (WAIT_STATES == 0)) ||
               ((state == WAIT) && (cnt == 4'(WAIT_STATES - 1)));
    diff     = req_c.addr - BASE_ADDR;
    in_range = (req_c.addr >= BASE_ADDR) && (diff < ADDR_SIZE'(8));
    off      = diff[2:0];
    wr       = commit && req_c.write && in_range;
    // A push on full only errors if the peripheral is not popping on the same edge.
    err_acc  = !in_range ||
               ((off == 3'd5) && (!req_c.write || (full && !pop))) ||
               ((off == 3'd7) && req_c.write);
    push     = wr && (off == 3'd5) && (!full || pop);
    rd_val   = '0;
    if (!req_c.write && !err_acc) begin
      case (off)
        3'd0:    rd_val = scratch0;
        3'd1:    rd_val = scratch1;
        3'd2:    rd_val = timer;
        3'd3:    rd_val = timer_cmp;
        3'd4:    rd_val = status_word;
        3'd6:    rd_val = WORD_SIZE'(irq_en);
        3'd7:    rd_val = ID_VAL;
        default: rd_val = '0;
      endcase
    end
  end

  // Bus FSM: accept, count wait states, then strobe a registered response.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state       <= IDLE;
      req_q       <= '0;
      cnt         <= '0;
      rdy_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid && rdy_q) begin
            req_q <= req_c;
            rdy_q <= 1'b0;
            cnt   <= '0;
            state <= (WAIT_STATES == 0) ? RESP : WAIT;
          end else begin
            rdy_q <= 1'b1;
          end
        end
        WAIT: begin
          if (cnt == 4'(WAIT_STATES - 1)) state <= RESP;
          else                            cnt   <= cnt + 4'd1;
        end
        RESP: begin
          rsp_valid_q <= 1'b0;
          rdy_q       <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (commit) begin
        rsp_valid_q <= 1'b1;
        rsp_rdata_q <= rd_val;
        rsp_err_q   <= err_acc;
      end
    end
  end

  // Register file, timer, sticky status and FIFO pointers.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      scratch0  <= '0;
      scratch1  <= '0;
      timer     <= '0;
      timer_cmp <= '1;
      st_match  <= 1'b0;
      st_err    <= 1'b0;
      irq_en    <= 1'b0;
      wptr      <= '0;
      rptr      <= '0;
    end else begin
      timer <= (wr && off == 3'd2) ? req_c.wdata : timer + WORD_SIZE'(1);
      if (wr && off == 3'd0) scratch0  <= req_c.wdata;
      if (wr && off == 3'd1) scratch1  <= req_c.wdata;
      if (wr && off == 3'd3) timer_cmp <= req_c.wdata;
      if (wr && off == 3'd6) irq_en    <= req_c.wdata[0];
      // Set beats a same-edge W1C on the match bit.
      st_match <= (st_match & ~(wr && off == 3'd4 && req_c.wdata[0])) | (timer == timer_cmp);
      st_err   <= (st_err & ~(wr && off == 3'd4 && req_c.wdata[3])) | (commit && err_acc);
      if (push) wptr <= wptr + (PW+1)'(1);
      if (pop)  rptr <= rptr + (PW+1)'(1);
    end
  end

  // FIFO storage; contents are masked by tx_valid so no reset is needed.
  always_ff @(posedge CLK) begin
    if (push) mem[wptr[PW-1:0]] <= req_c.wdata;
  end
endmodule

// File: tb/tb_mmio_responder.sv
// Scoreboard bench for mmio_responder: expected responses queued at issue, compared on rsp_valid.
module tb_mmio_responder;
  localparam int          WS   = 1;
  localparam logic [18:0] BASE = 19'h7FF00;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        tx_ready = 1'b0;
  logic [18:0] tx_data;
  logic        tx_valid, irq;

  mmio_responder_if #(.ADDR_SIZE(19), .WORD_SIZE(19)) bus_if ();

  mmio_responder #(
    .WORD_SIZE(19), .ADDR_SIZE(19), .BASE_ADDR(BASE), .WAIT_STATES(WS), .FIFO_DEPTH(4)
  ) dut (
    .CLK(CLK), .RESET(RESET), .bus(bus_if),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .irq(irq)
  );

  always #5 CLK = ~CLK;

  typedef struct { logic [18:0] rd; logic err; } exp_t;
  exp_t        sb_q[$];
  logic [18:0] tx_q[$];
  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Response monitor: every strobe must match the oldest queued expectation.
  always @(negedge CLK) begin : mon
    exp_t e;
    if (bus_if.rsp_valid === 1'b1) begin
      if (sb_q.size() == 0) chk("rsp_unexpected", bus_if.rsp_valid, 0);
      else begin
        e = sb_q.pop_front();
        chk("rsp_rdata", bus_if.rsp_rdata, e.rd);
        chk("rsp_err", bus_if.rsp_err, e.err);
      end
    end
  end

  // One bus transaction; optionally raises tx_ready for exactly the commit edge.
  task automatic xfer(input logic w, input logic [18:0] a, input logic [18:0] wd,
                      input logic [18:0] exp_rd, input logic exp_err, input bit pop_commit);
    exp_t e;
    int n, lat;
    e.rd = exp_rd; e.err = exp_err;
    sb_q.push_back(e);
    bus_if.req_valid = 1'b1; bus_if.req_write = w;
    bus_if.req_addr  = a;    bus_if.req_wdata = wd;
    n = 0;
    while (bus_if.req_ready !== 1'b1 && n < 50) begin @(posedge CLK); #1; n++; end
    chk("rdy_before_accept", bus_if.req_ready, 1);
    @(posedge CLK); #1;
    bus_if.req_valid = 1'b0;
    chk("rdy_after_accept", bus_if.req_ready, 0);
    lat = 0;
    while (bus_if.rsp_valid !== 1'b1 && lat < 50) begin
      if (pop_commit) tx_ready = (lat == WS - 1);
      @(posedge CLK); #1;
      lat++;
    end
    if (pop_commit) tx_ready = 1'b0;
    chk("rsp_latency", lat, WS);
    chk("rdy_in_resp", bus_if.req_ready, 0);
    @(posedge CLK); #1;
  endtask

  task automatic wr(input int off, input logic [18:0] d, input logic err);
    xfer(1'b1, BASE + 19'(off), d, 19'h0, err, 1'b0);
  endtask

  task automatic rd(input int off, input logic [18:0] exp, input logic err);
    xfer(1'b0, BASE + 19'(off), 19'h0, exp, err, 1'b0);
  endtask

  // Pop n words through the peripheral side, checking order against the model.
  task automatic drain(input int n);
    tx_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      chk("tx_valid", tx_valid, 1);
      chk("tx_data", tx_data, tx_q.pop_front());
      @(posedge CLK); #1;
    end
    tx_ready = 1'b0;
    chk("tx_empty", tx_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    logic [18:0] d, t;
    int n;
    bus_if.req_valid = 1'b0; bus_if.req_write = 1'b0;
    bus_if.req_addr  = '0;   bus_if.req_wdata = '0;

    // Reset state
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_ready", bus_if.req_ready, 0);
    chk("rst_rsp_valid", bus_if.rsp_valid, 0);
    chk("rst_rsp_rdata", bus_if.rsp_rdata, 0);
    chk("rst_rsp_err", bus_if.rsp_err, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_irq", irq, 0);
    @(negedge CLK) RESET = 1'b1;
    @(posedge CLK); #1;
    chk("ready_after_release", bus_if.req_ready, 1);

    // Scratch and plain RW registers
    rd(3, 19'h7FFFF, 1'b0);
    wr(0, 19'h12345, 1'b0);
    rd(0, 19'h12345, 1'b0);
    wr(1, 19'h5555A, 1'b0);
    rd(1, 19'h5555A, 1'b0);
    rd(0, 19'h12345, 1'b0);
    wr(6, 19'h7FFFF, 1'b0);
    rd(6, 19'h1, 1'b0);
    wr(6, 19'h0, 1'b0);
    rd(6, 19'h0, 1'b0);

    // Error accesses and sticky error flag
    rd(8, 19'h0, 1'b1);
    xfer(1'b0, BASE - 19'd1, 19'h0, 19'h0, 1'b1, 1'b0);
    rd(5, 19'h0, 1'b1);
    wr(7, 19'h00BAD, 1'b1);
    rd(7, 19'h1C0DE, 1'b0);
    rd(4, 19'hC, 1'b0);
    wr(4, 19'h8, 1'b0);
    rd(4, 19'h4, 1'b0);

    // FIFO fill past full, then drain in order
    for (int i = 0; i < 5; i++) begin
      d = 19'($urandom);
      if (i < 4) tx_q.push_back(d);
      wr(5, d, i == 4);
    end
    chk("tx_head_valid", tx_valid, 1);
    rd(4, 19'hA, 1'b0);
    drain(4);
    wr(4, 19'h8, 1'b0);

    // Push on full with a same-edge pop
    for (int i = 0; i < 4; i++) begin
      d = 19'($urandom);
      tx_q.push_back(d);
      wr(5, d, 1'b0);
    end
    d = 19'h3C3C3;
    void'(tx_q.pop_front());
    tx_q.push_back(d);
    xfer(1'b1, BASE + 19'd5, d, 19'h0, 1'b0, 1'b1);
    rd(4, 19'h2, 1'b0);
    drain(4);

    // Timer compare interrupt
    wr(6, 19'h1, 1'b0);
    wr(3, 19'd20, 1'b0);
    wr(2, 19'd10, 1'b0);
    chk("irq_before_match", irq, 0);
    n = 0;
    while (irq !== 1'b1 && n < 40) begin @(posedge CLK); #1; n++; end
    chk("irq_delay", n, 10);
    rd(4, 19'h5, 1'b0);
    wr(4, 19'h1, 1'b0);
    chk("irq_cleared", irq, 0);
    rd(4, 19'h4, 1'b0);
    // Match set on the same edge as W1C: set wins
    wr(2, 19'(20 - 1 - WS), 1'b0);
    wr(4, 19'h1, 1'b0);
    rd(4, 19'h5, 1'b0);
    chk("irq_set_wins", irq, 1);
    // Timer readback and wrap
    wr(2, 19'd100, 1'b0);
    t = 19'd100 + 19'(1 + WS);
    rd(2, t, 1'b0);
    wr(2, 19'h7FFFE, 1'b0);
    t = 19'h7FFFE + 19'(1 + WS);
    rd(2, t, 1'b0);

    // Reset during the wait state of a SCRATCH1 write
    bus_if.req_valid = 1'b1; bus_if.req_write = 1'b1;
    bus_if.req_addr  = BASE + 19'd1; bus_if.req_wdata = 19'h2AAAA;
    @(posedge CLK); #1;
    bus_if.req_valid = 1'b0;
    RESET = 1'b0;
    #1;
    chk("abort_ready", bus_if.req_ready, 0);
    chk("abort_rsp_valid", bus_if.rsp_valid, 0);
    chk("abort_irq", irq, 0);
    repeat (3) @(posedge CLK);
    @(negedge CLK) RESET = 1'b1;
    @(posedge CLK); #1;
    chk("abort_ready_release", bus_if.req_ready, 1);
    rd(1, 19'h0, 1'b0);
    rd(3, 19'h7FFFF, 1'b0);
    rd(4, 19'h4, 1'b0);

    repeat (2) @(posedge CLK);
    chk("sb_leftover", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
